// File: rtl/mips_alu_pkg.sv
// Shared definitions for the EX-stage ALU and the iterative multiply/divide sequencer.
package mips_alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam int MD_ITER = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// MULTU/DIVU sequencer: shift-add multiply and restoring divide, one borrowed ALU op per cycle.
module alu_muldiv_seq
   import mips_alu_pkg::*;
#(
   parameter int ITER = MD_ITER
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        div_sel,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        ready,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        alu_req,
   output logic [2:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result
);

   md_state_t   state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;    // product high half (MULTU) or partial remainder (DIVU)
   logic [31:0] low_q, low_d;    // multiplier shifting out / dividend shifting out, quotient in
   logic [31:0] opb_q, opb_d;
   logic        div_q, div_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] sh;
   logic        carry;
   logic        qbit;

   assign sh = {acc_q[30:0], low_q[31]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         low_q   <= '0;
         opb_q   <= '0;
         div_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         low_q   <= low_d;
         opb_q   <= opb_d;
         div_q   <= div_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      low_d   = low_q;
      opb_d   = opb_q;
      div_d   = div_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      alu_op  = 3'b000;
      alu_a   = '0;
      alu_b   = '0;
      carry   = 1'b0;
      qbit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               cnt_d = '0;
               div_d = div_sel;
               acc_d = '0;
               if (div_sel) begin
                  low_d = src_a;
                  opb_d = src_b;
                  if (src_b == '0) begin
                     state_d = DONE;
                     hi_d    = src_a;
                     lo_d    = 32'hFFFF_FFFF;
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  low_d   = src_b;
                  opb_d   = src_a;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // ALU drive comes from registered state only; flush just discards the step.
            if (div_q) begin
               alu_op = ALU_SUB;
               alu_a  = sh;
               alu_b  = opb_q;
               qbit   = acc_q[31] | (sh >= opb_q);
               acc_d  = qbit ? alu_result : sh;
               low_d  = {low_q[30:0], qbit};
            end else begin
               alu_op = ALU_ADD;
               alu_a  = acc_q;
               alu_b  = low_q[0] ? opb_q : '0;
               carry  = alu_result < acc_q;
               acc_d  = {carry, alu_result[31:1]};
               low_d  = {alu_result[0], low_q[31:1]};
            end
            cnt_d = cnt_q + 6'd1;
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q == 6'(ITER - 1)) begin
               hi_d    = acc_d;
               lo_d    = low_d;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ready   = (state_q == IDLE);
   assign done    = (state_q == DONE);
   assign alu_req = (state_q == RUN);
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a timeline-level reference model and per-cycle compare.
module tb_alu_muldiv_seq;
   import mips_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        div_sel = 1'b0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        flush = 1'b0;
   logic        ready, done, alu_req;
   logic [31:0] hi, lo, alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_result;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // shared ALU as seen by the sequencer
   always_comb begin
      alu_result = '0;
      if (alu_op == ALU_ADD) alu_result = alu_a + alu_b;
      else if (alu_op == ALU_SUB) alu_result = alu_a - alu_b;
   end

   alu_muldiv_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .div_sel(div_sel),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .ready(ready), .done(done), .hi(hi), .lo(lo),
      .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: result from 64-bit arithmetic, timing as cycles of ALU ownership left.
   int          m_left;
   logic        m_done, m_div;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0; m_done <= 1'b0; m_div <= 1'b0;
         m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_done) begin
         end else if (m_left != 0) begin
            if (flush) m_left <= 0;
            else begin
               m_left <= m_left - 1;
               if (m_left == 1) begin
                  m_done <= 1'b1; m_hi <= p_hi; m_lo <= p_lo;
               end
            end
         end else if (start && !flush) begin
            if (div_sel && src_b == 0) begin
               m_done <= 1'b1; m_hi <= src_a; m_lo <= 32'hFFFF_FFFF;
            end else begin
               m_left <= MD_ITER;
               m_div  <= div_sel;
               if (div_sel) begin
                  p_lo <= src_a / src_b;
                  p_hi <= src_a % src_b;
               end else begin
                  {p_hi, p_lo} <= 64'(src_a) * 64'(src_b);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 64'(ready), 64'(m_left == 0 && !m_done));
         chk("done", 64'(done), 64'(m_done));
         chk("alu_req", 64'(alu_req), 64'(m_left != 0));
         chk("hi", 64'(hi), 64'(m_hi));
         chk("lo", 64'(lo), 64'(m_lo));
         if (m_left != 0) chk("alu_op", 64'(alu_op), 64'(m_div ? ALU_SUB : ALU_ADD));
         else chk("alu_idle", {29'd0, alu_op, alu_a}, 64'(alu_b));
         if (m_left == 0) chk("alu_b_idle", 64'(alu_b), 64'd0);
      end
   end

   task automatic launch(input logic d, input logic [31:0] a, input logic [31:0] b);
      int w = 0;
      @(negedge clk);
      while (!ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("launch_ready", 64'(ready), 64'd1);
      div_sel = d; src_a = a; src_b = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic do_op(input string name, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int elat, input int ereq);
      int lat = 0;
      int req = 0;
      launch(d, a, b);
      do begin
         @(negedge clk);
         lat++;
         if (alu_req) req++;
      end while (!done && lat < 100);
      chk({name, "_lat"}, 64'(lat), 64'(elat));
      chk({name, "_req"}, 64'(req), 64'(ereq));
      chk({name, "_hi"}, 64'(hi), 64'(ehi));
      chk({name, "_lo"}, 64'(lo), 64'(elo));
   endtask

   initial begin
      int nd;
      #12;
      #1 chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_outs", {hi, lo}, 64'd0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      do_op("mul7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 33, 32);
      do_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 32);
      do_op("div100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 33, 32);
      do_op("divovf", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1, 33, 32);
      do_op("div5_0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0);

      // flush mid-RUN with an ignored start pulse before it
      launch(1'b0, 32'd9, 32'd9);
      repeat (4) @(negedge clk);
      div_sel = 1'b1; src_a = 32'd77; src_b = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_ready", 64'(ready), 64'd1);
      chk("flush_keep", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("flush_nodone", 64'(nd), 64'd0);

      // start during DONE is dropped
      launch(1'b1, 32'd8, 32'd0);
      @(negedge clk);
      chk("dz_done", 64'(done), 64'd1);
      div_sel = 1'b0; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("done_start_ign", 64'(ready), 64'd1);
      chk("dz_hi", 64'(hi), 64'd8);

      // flush beats start in IDLE
      start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("idle_flush_wins", 64'(ready), 64'd1);

      // async reset mid-RUN
      launch(1'b0, 32'h1234, 32'h10);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rstrun_hilo", {hi, lo}, 64'd0);
      chk("rstrun_alu", {alu_a, alu_b}, 64'd0);
      chk("rstrun_ctl", {59'd0, alu_op, done, alu_req}, 64'd0);
      chk("rstrun_ready", 64'(ready), 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      do_op("mul3x5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 33, 32);

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
